// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, IF/ID register, redirect/stall/fault handling
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched / perf_stall_cycles).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   imem_pc             byte address to the instruction memory (the PC register)
//   imem_instr          instruction returned combinationally for imem_pc
//   stall               hazard-unit stall: hold PC and IF/ID
//   redirect_valid/_pc  EX-stage taken branch or jump and its target
//   ifid_valid/_pc/_instr/_pc_plus4   IF/ID pipeline register towards decode
//   fetch_fault         sticky fault flag (misaligned or out-of-range fetch)
//   fault_pc            offending address captured when fetch_fault rises
//   perf_fetched        (FETCH_PERF_CNT_EN) count of normal-fetch captures
//   perf_stall_cycles   (FETCH_PERF_CNT_EN) count of RUN cycles stalled without redirect

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles
`endif
);

  // One bit wider than the PC so the limit itself is representable for any depth.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        fault_q, fault_d;
  logic [31:0] fpc_q, fpc_d;

  logic [31:0] pc_plus4;
  logic        pc_ok;
  logic        redirect_ok;
  logic        fetch_en;
  logic        stall_cnt_en;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ({1'b0, a} < PC_LIMIT);
  endfunction

  assign pc_plus4    = pc_q + 32'd4;
  assign pc_ok       = addr_ok(pc_q);
  assign redirect_ok = addr_ok(redirect_pc);

  // A PC that has walked off the end of memory faults on the next edge no
  // matter what else is requested; the fetch itself is already invalid.
  assign fetch_en     = (state_q == S_RUN) && pc_ok && !redirect_valid && !stall;
  assign stall_cnt_en = (state_q == S_RUN) && stall && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ipc_q   <= 32'h0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      fault_q <= 1'b0;
      fpc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        if (!pc_ok) begin
          fault_d = 1'b1;
          fpc_d   = pc_q;
          valid_d = 1'b0;
          state_d = S_HALTED;
        end else if (redirect_valid) begin
          valid_d = 1'b0;
          if (redirect_ok) begin
            pc_d = redirect_pc;
          end else begin
            fault_d = 1'b1;
            fpc_d   = redirect_pc;
            state_d = S_HALTED;
          end
        end else if (!stall) begin
          instr_d = imem_instr;
          ipc_d   = pc_q;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end
      end

      S_HALTED: begin
        valid_d = 1'b0;
      end

      default: begin
        valid_d = 1'b0;
        state_d = S_HALTED;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched      <= 32'h0;
      perf_stall_cycles <= 32'h0;
    end else begin
      if (fetch_en) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (stall_cnt_en) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`else
  logic unused_cnt_en;
  assign unused_cnt_en = fetch_en ^ stall_cnt_en;
`endif

  assign imem_pc       = pc_q;
  assign ifid_valid    = valid_q;
  assign ifid_pc       = ipc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus4 = pc4_q;
  assign fetch_fault   = fault_q;
  assign fault_pc      = fpc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        fetch_fault;
  logic [31:0] fault_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
`endif

  int checks = 0;
  int fails  = 0;

  logic [31:0] mem [256];

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instr = (imem_pc < 32'd1024) ? mem[imem_pc[9:2]] : 32'h0;

  // Reference model: 0 = booting, 1 = running, 2 = halted
  int          m_phase;
  logic [31:0] m_pc, m_ipc, m_instr, m_pc4, m_fpc;
  logic        m_v, m_fault;
  logic [31:0] m_fetched, m_stalls;

  task automatic model_reset();
    m_phase = 0; m_pc = 32'h0; m_v = 1'b0; m_ipc = 0; m_instr = 0; m_pc4 = 0;
    m_fault = 1'b0; m_fpc = 0; m_fetched = 0; m_stalls = 0;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [31:0] rpc);
    longint unsigned pcl, rpl;
    pcl = longint'(m_pc);
    rpl = longint'(rpc);
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (s && !rv) m_stalls = m_stalls + 1;
      if ((pcl % 4) != 0 || pcl >= 1024) begin
        m_fault = 1'b1; m_fpc = m_pc; m_v = 1'b0; m_phase = 2;
      end else if (rv) begin
        m_v = 1'b0;
        if ((rpl % 4) == 0 && rpl < 1024) m_pc = rpc;
        else begin m_fault = 1'b1; m_fpc = rpc; m_phase = 2; end
      end else if (!s) begin
        m_instr = mem[pcl / 4]; m_ipc = m_pc; m_pc4 = 32'(pcl + 4); m_v = 1'b1;
        m_pc = 32'(pcl + 4);
        m_fetched = m_fetched + 1;
      end
    end
  endtask

  task automatic cycle(input logic s, input logic rv, input logic [31:0] rpc);
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    model_step(s, rv, rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (imem_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", imem_pc); end
    checks++; if (ifid_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
    checks++; if ({ifid_pc, ifid_instr, ifid_pc_plus4} !== 96'h0) begin fails++; $display("FAIL reset_ifid: got %h %h %h want 0", ifid_pc, ifid_instr, ifid_pc_plus4); end
    checks++; if ({fetch_fault, fault_pc} !== 33'h0) begin fails++; $display("FAIL reset_fault: got %b %h want 0", fetch_fault, fault_pc); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_boot_and_fetch();
    mem[0] = 32'hDEADBEEF; mem[1] = 32'hCAFEBABE; mem[2] = 32'h1234_5678; mem[16] = 32'h0BAD_F00D;
    cycle(0, 0, 0);
    checks++; if (ifid_valid !== 1'b0 || imem_pc !== 32'h0) begin fails++; $display("FAIL boot_cycle: got v=%b pc=%h want v=0 pc=0", ifid_valid, imem_pc); end
    cycle(0, 0, 0);
    checks++; if ({ifid_valid, ifid_pc, ifid_instr, ifid_pc_plus4} !== {1'b1, 32'h0, 32'hDEADBEEF, 32'h4}) begin fails++; $display("FAIL fetch0: got %b %h %h %h want 1 0 deadbeef 4", ifid_valid, ifid_pc, ifid_instr, ifid_pc_plus4); end
    cycle(0, 0, 0);
    checks++; if ({ifid_valid, ifid_pc, ifid_instr, ifid_pc_plus4} !== {1'b1, 32'h4, 32'hCAFEBABE, 32'h8}) begin fails++; $display("FAIL fetch4: got %b %h %h %h want 1 4 cafebabe 8", ifid_valid, ifid_pc, ifid_instr, ifid_pc_plus4); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      checks++; if (imem_pc !== 32'h8) begin fails++; $display("FAIL stall_pc[%0d]: got %h want 8", i, imem_pc); end
      checks++; if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h4, 32'hCAFEBABE}) begin fails++; $display("FAIL stall_hold[%0d]: got %b %h %h want 1 4 cafebabe", i, ifid_valid, ifid_pc, ifid_instr); end
    end
    cycle(0, 0, 0);
    checks++; if ({ifid_pc, ifid_instr, imem_pc} !== {32'h8, 32'h1234_5678, 32'hC}) begin fails++; $display("FAIL stall_resume: got %h %h %h want 8 12345678 c", ifid_pc, ifid_instr, imem_pc); end
  endtask

  task automatic test_redirect_under_stall();
    cycle(1, 1, 32'h40);
    checks++; if (imem_pc !== 32'h40 || ifid_valid !== 1'b0) begin fails++; $display("FAIL redirect: got pc=%h v=%b want 40 0", imem_pc, ifid_valid); end
    cycle(0, 0, 0);
    checks++; if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h40, 32'h0BAD_F00D}) begin fails++; $display("FAIL redirect_fetch: got %b %h %h want 1 40 0badf00d", ifid_valid, ifid_pc, ifid_instr); end
  endtask

  task automatic test_bad_redirect();
    cycle(0, 1, 32'h42);
    checks++; if ({fetch_fault, fault_pc, ifid_valid} !== {1'b1, 32'h42, 1'b0}) begin fails++; $display("FAIL bad_redirect: got %b %h %b want 1 42 0", fetch_fault, fault_pc, ifid_valid); end
    checks++; if (imem_pc !== 32'h44) begin fails++; $display("FAIL bad_redirect_pc: got %h want 44", imem_pc); end
    for (int i = 0; i < 3; i++) begin
      cycle(i[0], 1, 32'h80);
      checks++; if ({imem_pc, fetch_fault, ifid_valid} !== {32'h44, 1'b1, 1'b0}) begin fails++; $display("FAIL halted_frozen[%0d]: got %h %b %b want 44 1 0", i, imem_pc, fetch_fault, ifid_valid); end
    end
    do_reset();
    checks++; if ({fetch_fault, fault_pc, imem_pc} !== {1'b0, 32'h0, 32'h0}) begin fails++; $display("FAIL fault_clear: got %b %h %h want 0 0 0", fetch_fault, fault_pc, imem_pc); end
  endtask

  task automatic test_overflow();
    mem[254] = 32'hAAAA_0001; mem[255] = 32'hBBBB_0002;
    cycle(0, 0, 0);
    cycle(0, 1, 32'h3F8);
    cycle(0, 0, 0);
    checks++; if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h3F8, 32'hAAAA_0001}) begin fails++; $display("FAIL ovf_3f8: got %b %h %h want 1 3f8 aaaa0001", ifid_valid, ifid_pc, ifid_instr); end
    cycle(0, 0, 0);
    checks++; if ({ifid_valid, ifid_pc, ifid_instr, ifid_pc_plus4} !== {1'b1, 32'h3FC, 32'hBBBB_0002, 32'h400}) begin fails++; $display("FAIL ovf_3fc: got %b %h %h %h want 1 3fc bbbb0002 400", ifid_valid, ifid_pc, ifid_instr, ifid_pc_plus4); end
    checks++; if ({imem_pc, fetch_fault} !== {32'h400, 1'b0}) begin fails++; $display("FAIL ovf_pre: got %h %b want 400 0", imem_pc, fetch_fault); end
    cycle(0, 0, 0);
    checks++; if ({fetch_fault, fault_pc, ifid_valid} !== {1'b1, 32'h400, 1'b0}) begin fails++; $display("FAIL ovf_fault: got %b %h %b want 1 400 0", fetch_fault, fault_pc, ifid_valid); end
    cycle(0, 1, 32'h10);
    checks++; if (imem_pc !== 32'h400) begin fails++; $display("FAIL ovf_nowrap: got %h want 400", imem_pc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    checks++; if (ifid_valid !== 1'b1) begin fails++; $display("FAIL async_pre: got %b want 1", ifid_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({imem_pc, ifid_valid} !== {32'h0, 1'b0}) begin fails++; $display("FAIL async_clear: got %h %b want 0 0", imem_pc, ifid_valid); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if ({perf_fetched, perf_stall_cycles} !== 64'h0) begin fails++; $display("FAIL async_perf: got %h %h want 0 0", perf_fetched, perf_stall_cycles); end
`endif
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    logic        s, rv;
    logic [31:0] rpc;
    int          r, halted_for;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    halted_for = 0;
    for (int n = 0; n < 600; n++) begin
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      r  = $urandom_range(0, 19);
      if (r == 0)      rpc = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      else if (r == 1) rpc = ($urandom_range(0, 1) == 0) ? 32'h3F8 : 32'h3FC;
      else if (r == 2) rpc = 32'h400 + ($urandom_range(0, 15) * 4);
      else             rpc = $urandom_range(0, 255) * 4;
      cycle(s, rv, rpc);
      checks++; if (imem_pc !== m_pc) begin fails++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, imem_pc, m_pc); end
      checks++; if (ifid_valid !== m_v) begin fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, ifid_valid, m_v); end
      checks++; if ({ifid_pc, ifid_instr, ifid_pc_plus4} !== {m_ipc, m_instr, m_pc4}) begin fails++; $display("FAIL rnd_ifid[%0d]: got %h %h %h want %h %h %h", n, ifid_pc, ifid_instr, ifid_pc_plus4, m_ipc, m_instr, m_pc4); end
      checks++; if ({fetch_fault, fault_pc} !== {m_fault, m_fpc}) begin fails++; $display("FAIL rnd_fault[%0d]: got %b %h want %b %h", n, fetch_fault, fault_pc, m_fault, m_fpc); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if ({perf_fetched, perf_stall_cycles} !== {m_fetched, m_stalls}) begin fails++; $display("FAIL rnd_perf[%0d]: got %0d %0d want %0d %0d", n, perf_fetched, perf_stall_cycles, m_fetched, m_stalls); end
`endif
      if (m_phase == 2) halted_for++;
      if (halted_for > 3) begin
        @(posedge clk);
        #1;
        do_reset();
        halted_for = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    test_reset();
    test_boot_and_fetch();
    test_stall();
    test_redirect_under_stall();
    test_bad_redirect();
    test_overflow();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
